// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types and default widths.
// ifid_entry_t describes one IF/ID buffer entry in the default 32-bit build.
package cpu_types_pkg;

    localparam int IFID_DEPTH_DEF = 4;
    localparam int IFID_PC_W      = 32;
    localparam int IFID_INSTR_W   = 32;

    typedef struct packed {
        logic [IFID_PC_W-1:0]    npc;
        logic [IFID_INSTR_W-1:0] instr;
    } ifid_entry_t;

endpackage

// File: rtl/ifid_buf_mem.sv
// IF/ID buffer storage: register array with one write port
// and one asynchronous read port. Contents are intentionally not reset.
module ifid_buf_mem
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = IFID_DEPTH_DEF,
    parameter int WIDTH = IFID_PC_W + IFID_INSTR_W
) (
    input  logic                     CLK,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/ifid_buf.sv
// IF/ID decoupling FIFO between fetch and decode with single-cycle flush
// and optional same-cycle bypass when the buffer is empty.
module ifid_buf
    import cpu_types_pkg::*;
#(
    parameter int DEPTH   = IFID_DEPTH_DEF,
    parameter int PC_W    = IFID_PC_W,
    parameter int INSTR_W = IFID_INSTR_W,
    parameter int BYPASS  = 0
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   flush,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic [PC_W-1:0]        enq_npc,
    input  logic [INSTR_W-1:0]     enq_instr,
    output logic                   deq_valid,
    input  logic                   deq_ready,
    output logic [PC_W-1:0]        deq_npc,
    output logic [INSTR_W-1:0]     deq_instr,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = PC_W + INSTR_W;
    localparam logic [CNT_W-1:0] L_DEPTH = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_byp_en;
    logic             w_nonempty;
    logic             w_enq_fire;
    logic             w_byp_fire;
    logic             w_we;
    logic             w_deq_fire;
    logic             w_rd_fire;
    logic [ENT_W-1:0] w_rdata;

    assign w_byp_en   = (BYPASS != 0);
    assign w_nonempty = (r_count != '0);

    assign enq_ready  = (r_count < L_DEPTH);
    assign empty      = !w_nonempty;
    assign full       = (r_count == L_DEPTH);
    assign count      = r_count;

    assign deq_valid  = !flush && (w_nonempty || (w_byp_en && enq_valid));

    assign w_enq_fire = enq_valid && enq_ready && !flush;
    assign w_deq_fire = deq_valid && deq_ready;
    // A consumed bypass entry never touches the array or the count.
    assign w_byp_fire = w_byp_en && !w_nonempty && w_enq_fire && deq_ready;
    assign w_we       = w_enq_fire && !w_byp_fire;
    assign w_rd_fire  = w_deq_fire && w_nonempty;

    ifid_buf_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_mem (
        .CLK   (CLK),
        .we    (w_we),
        .waddr (r_wr_ptr),
        .wdata ({enq_npc, enq_instr}),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_we) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_we, w_rd_fire})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Zero when nothing is presentable so stale array data never leaks out.
    always_comb begin
        deq_npc   = '0;
        deq_instr = '0;
        if (w_nonempty) begin
            {deq_npc, deq_instr} = w_rdata;
        end else if (w_byp_en && enq_valid) begin
            deq_npc   = enq_npc;
            deq_instr = enq_instr;
        end
    end

endmodule

// File: tb/tb_ifid_buf.sv
// Scoreboard bench for ifid_buf: u_buf0 (BYPASS=0) is tracked cycle by cycle
// against a queue model; u_buf1 (BYPASS=1) covers same-cycle bypass.
module tb_ifid_buf;

    logic        CLK = 1'b0;
    logic        RST;
    logic        flush;
    logic        enq_valid;
    logic [31:0] enq_npc;
    logic [31:0] enq_instr;
    logic        deq_ready;

    logic        enq_ready0, deq_valid0, empty0, full0;
    logic [31:0] deq_npc0, deq_instr0;
    logic [2:0]  count0;
    logic        enq_ready1, deq_valid1, empty1, full1;
    logic [31:0] deq_npc1, deq_instr1;
    logic [2:0]  count1;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] sb[$];

    always #5 CLK = ~CLK;

    ifid_buf #(.DEPTH(4), .PC_W(32), .INSTR_W(32), .BYPASS(0)) u_buf0 (
        .CLK(CLK), .RST(RST), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready0),
        .enq_npc(enq_npc), .enq_instr(enq_instr),
        .deq_valid(deq_valid0), .deq_ready(deq_ready),
        .deq_npc(deq_npc0), .deq_instr(deq_instr0),
        .count(count0), .empty(empty0), .full(full0)
    );

    ifid_buf #(.DEPTH(4), .PC_W(32), .INSTR_W(32), .BYPASS(1)) u_buf1 (
        .CLK(CLK), .RST(RST), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready1),
        .enq_npc(enq_npc), .enq_instr(enq_instr),
        .deq_valid(deq_valid1), .deq_ready(deq_ready),
        .deq_npc(deq_npc1), .deq_instr(deq_instr1),
        .count(count1), .empty(empty1), .full(full1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock of u_buf0: drive, check against the model, advance the model.
    task automatic cycle0(input logic rst, input logic fl, input logic ev,
                          input logic [31:0] npc, input logic dr);
        logic exp_rdy;
        logic exp_dv;
        RST       = rst;
        flush     = fl;
        enq_valid = ev;
        enq_npc   = npc;
        enq_instr = ~npc;
        deq_ready = dr;
        #1;
        exp_rdy = (sb.size() < 4);
        exp_dv  = !fl && (sb.size() != 0);
        chk("count", 32'(count0), 32'(sb.size()));
        chk("enq_ready", 32'(enq_ready0), 32'(exp_rdy));
        chk("full", 32'(full0), 32'(sb.size() == 4));
        chk("empty", 32'(empty0), 32'(sb.size() == 0));
        chk("deq_valid", 32'(deq_valid0), 32'(exp_dv));
        if (sb.size() != 0) begin
            chk("deq_npc", deq_npc0, sb[0]);
            chk("deq_instr", deq_instr0, ~sb[0]);
        end else begin
            chk("deq_npc_zero", deq_npc0, 32'h0);
            chk("deq_instr_zero", deq_instr0, 32'h0);
        end
        if (rst || fl) begin
            sb.delete();
        end else begin
            if (exp_dv && dr) void'(sb.pop_front());
            if (ev && exp_rdy) sb.push_back(npc);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_all();
        RST = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        enq_npc = '0; enq_instr = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        sb.delete();
    endtask

    initial begin
        reset_all();
        // Reset state
        cycle0(0, 0, 0, 32'h0, 0);
        chk("rst_count1", 32'(count1), 32'h0);
        chk("rst_dv1", 32'(deq_valid1), 32'h0);

        // Fill to full, then offer a fifth entry that must be refused
        for (int i = 1; i <= 4; i++) cycle0(0, 0, 1, 32'(4 * i), 0);
        cycle0(0, 0, 1, 32'h14, 0);
        cycle0(0, 0, 0, 32'h0, 0);

        // Drain in order, then idle empty
        for (int i = 0; i < 5; i++) cycle0(0, 0, 0, 32'h0, 1);

        // Sustained enq+deq across pointer wrap at count=2
        cycle0(0, 0, 1, 32'h200, 0);
        cycle0(0, 0, 1, 32'h204, 0);
        for (int i = 2; i < 22; i++) cycle0(0, 0, 1, 32'(32'h200 + 4 * i), 1);
        for (int i = 0; i < 3; i++) cycle0(0, 0, 0, 32'h0, 1);

        // Flush with a concurrent enqueue of 0x40 and deq_ready high
        for (int i = 0; i < 3; i++) cycle0(0, 0, 1, 32'(32'h30 + 4 * i), 0);
        cycle0(0, 1, 1, 32'h40, 1);
        cycle0(0, 0, 1, 32'h50, 0);
        for (int i = 0; i < 3; i++) cycle0(0, 0, 0, 32'h0, 1);

        // Mid-operation reset at count=3
        for (int i = 0; i < 3; i++) cycle0(0, 0, 1, 32'(32'h60 + 4 * i), 0);
        cycle0(1, 0, 0, 32'h0, 0);
        cycle0(0, 0, 0, 32'h0, 1);

        // Bypass on an empty buffer, consumed the same cycle
        reset_all();
        enq_valid = 1'b1; enq_npc = 32'h100; enq_instr = ~32'h100; deq_ready = 1'b1;
        #1;
        chk("byp_dv", 32'(deq_valid1), 32'h1);
        chk("byp_npc", deq_npc1, 32'h100);
        chk("byp_instr", deq_instr1, ~32'h100);
        chk("byp_ready", 32'(enq_ready1), 32'h1);
        @(posedge CLK); #1;
        enq_valid = 1'b0; deq_ready = 1'b0;
        #1;
        chk("byp_count0", 32'(count1), 32'h0);
        chk("byp_empty", 32'(empty1), 32'h1);
        chk("byp_dv_after", 32'(deq_valid1), 32'h0);

        // Bypass offered but not consumed: entry lands in the array
        reset_all();
        enq_valid = 1'b1; enq_npc = 32'h100; enq_instr = ~32'h100; deq_ready = 1'b0;
        #1;
        chk("bypw_dv", 32'(deq_valid1), 32'h1);
        chk("bypw_npc", deq_npc1, 32'h100);
        @(posedge CLK); #1;
        enq_valid = 1'b0; enq_npc = 32'h0; enq_instr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bypw_count1", 32'(count1), 32'h1);
            chk("bypw_head", deq_npc1, 32'h100);
            chk("bypw_full", 32'(full1), 32'h0);
            @(posedge CLK); #1;
        end
        deq_ready = 1'b1;
        #1;
        chk("bypw_deq_instr", deq_instr1, ~32'h100);
        @(posedge CLK); #1;
        deq_ready = 1'b0;
        #1;
        chk("bypw_drained", 32'(count1), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
